pipe_csa_addsub: RTL

PIPE_CSA_ADDSUB -- requirements
Module: pipe_csa_addsub

---
 rtl/pipe_csa_addsub_if.sv | 33 +++
 rtl/pipe_csa_addsub.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipe_csa_addsub_if.sv
// rtl/pipe_csa_addsub_if.sv - operand/result handshake bundle for pipe_csa_addsub
//
// Purpose: groups the operand beat (in_valid/in_ready, a, b, cin, op) and the
// result beat (out_valid/out_ready, sum, cout, ovf, zero) of the adder.
// Modports:
//   master - producer of operands and consumer of results (the environment)
//   slave  - the adder itself
interface pipe_csa_addsub_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, cin, op, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, cin, op, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );
endinterface

// File: rtl/pipe_csa_addsub.sv
// rtl/pipe_csa_addsub.sv - two-stage pipelined carry-select adder/subtractor
//
// Purpose: computes a + b + cin (op = 0) or a - b (op = 1) with a two-stage
// valid/ready pipeline. Stage 1 precomputes both candidate sums for every
// SEG-bit segment; stage 2 resolves the carry-select chain and the flags.
// Ports:
//   clock - single clock, all state on posedge
//   reset - asynchronous active-high reset
//   bus   - pipe_csa_addsub_if.slave: operand beat in, result beat out
//           (sum, cout, ovf, zero are held while out_valid && !out_ready)
module pipe_csa_addsub #(
   parameter int WIDTH = 32,
   parameter int SEG   = 8
) (
   input logic              clock,
   input logic              reset,
   pipe_csa_addsub_if.slave bus
);
   localparam int SEG_SAFE = (SEG < 1) ? 1 : SEG;
   localparam int NSEG     = WIDTH / SEG_SAFE;

   generate
      if ((SEG < 1) || ((WIDTH % SEG_SAFE) != 0)) begin : g_bad_param
         $error("pipe_csa_addsub: SEG must be >= 1 and divide WIDTH");
      end
   endgenerate

   // handshake
   logic ready1;
   logic ready2;

   // stage 1 state
   logic             v1_q,      v1_d;
   logic [WIDTH-1:0] c0_sum_q,  c0_sum_d;   // per-segment sums, segment carry-in 0
   logic [WIDTH-1:0] c1_sum_q,  c1_sum_d;   // per-segment sums, segment carry-in 1
   logic [NSEG-1:0]  c0_cy_q,   c0_cy_d;
   logic [NSEG-1:0]  c1_cy_q,   c1_cy_d;
   logic [SEG-1:0]   seg0_sum_q, seg0_sum_d; // segment 0 resolved with the real carry-in
   logic             seg0_cy_q, seg0_cy_d;
   logic             sa_q,      sa_d;        // sign of a
   logic             sb_q,      sb_d;        // sign of effective b

   // stage 2 state
   logic             v2_q,   v2_d;
   logic [WIDTH-1:0] sum_q,  sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q,  ovf_d;
   logic             zero_q, zero_d;

   // combinational helpers
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic [SEG:0]     t0;
   logic [SEG:0]     t1;
   logic [WIDTH-1:0] res;
   logic             cy;

   assign ready2 = !v2_q || bus.out_ready;
   assign ready1 = !v1_q || ready2;

   // Subtract is a + ~b + 1, so the inverted b and a forced carry-in of 1
   // turn it into an ordinary add.
   assign b_eff   = bus.op ? ~bus.b : bus.b;
   assign cin_eff = bus.op | bus.cin;

   // Stage 1: candidate sums per segment
   always_comb begin
      v1_d       = v1_q;
      c0_sum_d   = c0_sum_q;
      c1_sum_d   = c1_sum_q;
      c0_cy_d    = c0_cy_q;
      c1_cy_d    = c1_cy_q;
      seg0_sum_d = seg0_sum_q;
      seg0_cy_d  = seg0_cy_q;
      sa_d       = sa_q;
      sb_d       = sb_q;
      t0         = '0;
      t1         = '0;
      if (ready1) begin
         v1_d = bus.in_valid;
         if (bus.in_valid) begin
            for (int k = 0; k < NSEG; k++) begin
               t0 = {1'b0, bus.a[k*SEG +: SEG]} + {1'b0, b_eff[k*SEG +: SEG]};
               t1 = t0 + {{SEG{1'b0}}, 1'b1};
               c0_sum_d[k*SEG +: SEG] = t0[SEG-1:0];
               c0_cy_d[k]             = t0[SEG];
               c1_sum_d[k*SEG +: SEG] = t1[SEG-1:0];
               c1_cy_d[k]             = t1[SEG];
            end
            t0 = {1'b0, bus.a[SEG-1:0]} + {1'b0, b_eff[SEG-1:0]}
               + {{SEG{1'b0}}, cin_eff};
            seg0_sum_d = t0[SEG-1:0];
            seg0_cy_d  = t0[SEG];
            sa_d       = bus.a[WIDTH-1];
            sb_d       = b_eff[WIDTH-1];
         end
      end
   end

   // Stage 2: ripple the segment carries through the select muxes
   always_comb begin
      v2_d   = v2_q;
      sum_d  = sum_q;
      cout_d = cout_q;
      ovf_d  = ovf_q;
      zero_d = zero_q;
      res    = '0;
      cy     = 1'b0;
      if (ready2) begin
         v2_d = v1_q;
         if (v1_q) begin
            res[SEG-1:0] = seg0_sum_q;
            cy           = seg0_cy_q;
            for (int k = 1; k < NSEG; k++) begin
               res[k*SEG +: SEG] = cy ? c1_sum_q[k*SEG +: SEG] : c0_sum_q[k*SEG +: SEG];
               cy                = cy ? c1_cy_q[k] : c0_cy_q[k];
            end
            sum_d  = res;
            cout_d = cy;
            ovf_d  = (sa_q == sb_q) && (res[WIDTH-1] != sa_q);
            // zero is registered alongside sum so it reads 0 out of reset
            zero_d = ~|res;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         v1_q       <= 1'b0;
         c0_sum_q   <= '0;
         c1_sum_q   <= '0;
         c0_cy_q    <= '0;
         c1_cy_q    <= '0;
         seg0_sum_q <= '0;
         seg0_cy_q  <= 1'b0;
         sa_q       <= 1'b0;
         sb_q       <= 1'b0;
         v2_q       <= 1'b0;
         sum_q      <= '0;
         cout_q     <= 1'b0;
         ovf_q      <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         v1_q       <= v1_d;
         c0_sum_q   <= c0_sum_d;
         c1_sum_q   <= c1_sum_d;
         c0_cy_q    <= c0_cy_d;
         c1_cy_q    <= c1_cy_d;
         seg0_sum_q <= seg0_sum_d;
         seg0_cy_q  <= seg0_cy_d;
         sa_q       <= sa_d;
         sb_q       <= sb_d;
         v2_q       <= v2_d;
         sum_q      <= sum_d;
         cout_q     <= cout_d;
         ovf_q      <= ovf_d;
         zero_q     <= zero_d;
      end
   end

   // Segment 0 candidates are kept for a uniform per-segment stage 1, but
   // stage 2 takes segment 0 from the version resolved with the real carry-in.
   logic unused_seg0_cand;
   assign unused_seg0_cand = ^{c0_sum_q[SEG-1:0], c1_sum_q[SEG-1:0], c0_cy_q[0], c1_cy_q[0]};

   assign bus.in_ready  = ready1;
   assign bus.out_valid = v2_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
endmodule
